bp_mmio_initiator: RTL
======================

# bp_mmio_initiator

Single-outstanding BedRock uncached memory-command initiator. It turns a simple local read/write request into an xce BedRock mem command, waits for the matching mem response, and returns read data or error status to the local client. It sits on the master side of device-register buses and drives CLINT/PLIC-style slices and other xce responders for config sequencers, debug hosts and boot loaders.

## Interface
- bp_params_p, e_bp_default_cfg: processor parameter set. Supplies paddr_width_p, lce_id_width_p, lce_assoc_p and the xce BedRock widths.
- src_id_p, 0: value driven into header.payload.lce_id; all other payload fields are 0.
- timeout_cycles_p, 1024: response watchdog limit, in cycles. Used only under BP_MMIO_TIMEOUT_EN; must be ≥ 2.
- clk_i in 1: single clock domain.
- reset_i in 1: synchronous, active-high reset.
- req_v_i in 1: local request valid.
- req_ready_and_o out 1: local request ready (ready-and handshake).
- req_w_i in 1: 1 = write, 0 = read.
- req_addr_i in paddr_width_p: byte address.
- req_size_i in 3: bp_bedrock_msg_size_e (1, 2, 4 or 8 bytes).
- req_data_i in dword_width_gp: right-aligned write data.
- resp_v_o out 1: local response valid.
- resp_data_o out dword_width_gp: read data, zero-extended per size; 0 for writes.
- resp_err_o out 1: response mismatch or timeout.
- resp_yumi_i in 1: local response consumed.
- mem_cmd_o out xce_mem_msg_width_lp: BedRock command message.
- mem_cmd_v_o out 1: command valid.
- mem_cmd_ready_and_i in 1: command ready (ready-and handshake).
- mem_resp_i in xce_mem_msg_width_lp: BedRock response message.
- mem_resp_v_i in 1: response valid.
- mem_resp_yumi_o out 1: response consumed.

## Operation
- The FSM has four states: e_ready, e_send, e_wait, e_done. The state register resets to e_ready.
- e_ready:
  - req_ready_and_o = 1.
  - On req_v_i, latch w, addr, size and data, then go to e_send.
- e_send:
  - mem_cmd_v_o = 1.
  - Command fields: msg_type = w ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd; subop = e_bedrock_store; addr and size from the latch; data = write data replicated across the dword at the request size (reads: 0).
  - On mem_cmd_ready_and_i, go to e_wait.
- e_wait:
  - mem_resp_yumi_o = mem_resp_v_i.
  - On accept, set err = (resp msg_type ≠ cmd msg_type) | (resp addr ≠ cmd addr).
  - Read data = resp data masked to the low 8·2^size bits. Writes return data 0.
  - Go to e_done.
- e_done:
  - resp_v_o = 1; data and err come from registers.
  - On resp_yumi_i, go to e_ready. The next request can be accepted in the following cycle.
- Stray responses: a mem_resp_v_i arriving in e_ready, e_send or e_done is yumi'd immediately and dropped; no state changes. This also drains late responses after a timeout.
- mem_cmd_o is driven from latched registers only and stays stable while mem_cmd_v_o is high and not accepted.

## Timing
- Reset values: req_ready_and_o = 0 while reset_i is high and 1 in the first cycle after. mem_cmd_v_o, mem_resp_yumi_o, resp_v_o, resp_err_o = 0. resp_data_o = 0. Timeout counter = 0.
- Minimum round trip: request accepted at cycle 0; mem_cmd_v_o at cycle 1 (accepted the same cycle if ready); response accepted at cycle 2 at the earliest; resp_v_o at cycle 3.
- Only one transaction is ever outstanding.
- Local-side backpressure is unbounded: resp_v_o holds with stable data until resp_yumi_i.
- Reset in any state returns the FSM to e_ready the next cycle. The in-flight transaction is abandoned, and its late response is drained as a stray.

## Configuration
- BP_MMIO_TIMEOUT_EN defined:
  - A log2(timeout_cycles_p)-bit counter clears on entry to e_wait and increments each cycle spent in e_wait without an accepted response.
  - On reaching timeout_cycles_p−1, the FSM enters e_done with resp_err_o = 1 and resp_data_o = all ones.
  - If a response arrives in the same cycle as the timeout, the response wins.
- BP_MMIO_TIMEOUT_EN undefined: no counter, e_wait waits indefinitely, and timeout_cycles_p is ignored.

## Test plan
- Write 8B, addr 0x30_4000, data 0x1234: mem_cmd_o uc_wr, size 8, data 0x1234, payload.lce_id = src_id_p. A matching response gives resp_v_o at cycle 3 with err 0 and data 0.
- Read 4B, addr 0x30_bffc, response data 0xDEADBEEF_00000005: resp_data_o = 0x00000000_00000005, err 0.
- mem_cmd_ready_and_i held low for 10 cycles: mem_cmd_v_o stays 1, mem_cmd_o stays bit-stable, req_ready_and_o stays 0. Ready on cycle 11 moves the FSM to e_wait.
- Response addr 0x30_4008 for a command to 0x30_4000, then resp_yumi_i held low for 5 cycles: resp_err_o = 1 held stable; e_ready re-entered after yumi.
- With BP_MMIO_TIMEOUT_EN and timeout_cycles_p = 16, no response: resp_v_o with err 1 and data 0xFFFF_FFFF_FFFF_FFFF after 16 cycles in e_wait. A later response is yumi'd the same cycle and not reported.
- reset_i pulsed during e_wait, then a new 1B read of 0x30_0000 with response data 0xAB: outputs clear, the late old response is dropped, and the new read returns 0xAB with err 0.

Source files
------------

// File: rtl/bp_mmio_initiator.sv
// Single-outstanding BedRock uncached mem-command initiator (local req/resp <-> xce mem cmd/resp).
// Define BP_MMIO_TIMEOUT_EN to enable the response watchdog (timeout_cycles_p).
module bp_mmio_initiator #(
  parameter int  paddr_width_p            = 40,
  parameter int  lce_id_width_p           = 4,
  parameter int  lce_assoc_p              = 8,
  parameter int  src_id_p                 = 0,
  parameter int  timeout_cycles_p         = 1024,
  localparam int dword_width_gp           = 64,
  localparam int way_id_width_lp          = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int xce_mem_payload_width_lp = way_id_width_lp + lce_id_width_p,
  localparam int xce_mem_hdr_width_lp     = 4 + 4 + paddr_width_p + 3 + xce_mem_payload_width_lp,
  localparam int xce_mem_msg_width_lp     = dword_width_gp + xce_mem_hdr_width_lp
) (
  input  logic                            clk_i,
  input  logic                            reset_i,

  input  logic                            req_v_i,
  output logic                            req_ready_and_o,
  input  logic                            req_w_i,
  input  logic [paddr_width_p-1:0]        req_addr_i,
  input  logic [2:0]                      req_size_i,
  input  logic [dword_width_gp-1:0]       req_data_i,

  output logic                            resp_v_o,
  output logic [dword_width_gp-1:0]       resp_data_o,
  output logic                            resp_err_o,
  input  logic                            resp_yumi_i,

  output logic [xce_mem_msg_width_lp-1:0] mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_and_i,

  input  logic [xce_mem_msg_width_lp-1:0] mem_resp_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o
);

  localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;
  localparam logic [3:0] e_bedrock_store     = 4'd0;

  typedef struct packed {
    logic [way_id_width_lp-1:0] way_id;
    logic [lce_id_width_p-1:0]  lce_id;
  } xce_mem_payload_s;

  typedef struct packed {
    xce_mem_payload_s           payload;
    logic [2:0]                 size;
    logic [paddr_width_p-1:0]   addr;
    logic [3:0]                 subop;
    logic [3:0]                 msg_type;
  } xce_mem_hdr_s;

  typedef struct packed {
    logic [dword_width_gp-1:0]  data;
    xce_mem_hdr_s               header;
  } xce_mem_msg_s;

  typedef enum logic [1:0] {e_ready, e_send, e_wait, e_done} state_e;

  state_e                    state_q, state_d;
  xce_mem_msg_s              cmd_q, cmd_d;
  logic [dword_width_gp-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  xce_mem_msg_s              resp_msg;
  logic                      cmd_is_wr;

  // Write data is replicated across the dword so any byte lane picks it up.
  function automatic logic [dword_width_gp-1:0] replicate_data(
    input logic [dword_width_gp-1:0] d,
    input logic [2:0]                size
  );
    case (size)
      3'd0:    replicate_data = {8{d[7:0]}};
      3'd1:    replicate_data = {4{d[15:0]}};
      3'd2:    replicate_data = {2{d[31:0]}};
      default: replicate_data = d;
    endcase
  endfunction

  function automatic logic [dword_width_gp-1:0] mask_data(
    input logic [dword_width_gp-1:0] d,
    input logic [2:0]                size
  );
    case (size)
      3'd0:    mask_data = {56'b0, d[7:0]};
      3'd1:    mask_data = {48'b0, d[15:0]};
      3'd2:    mask_data = {32'b0, d[31:0]};
      default: mask_data = d;
    endcase
  endfunction

  assign resp_msg  = mem_resp_i;
  assign cmd_is_wr = (cmd_q.header.msg_type == e_bedrock_mem_uc_wr);

  // Responses are always drained; outside e_wait they are strays and ignored.
  assign mem_resp_yumi_o = mem_resp_v_i & ~reset_i;

  assign mem_cmd_o   = cmd_q;
  assign resp_data_o = rdata_q;
  assign resp_err_o  = err_q;

`ifdef BP_MMIO_TIMEOUT_EN
  localparam int cnt_width_lp = $clog2(timeout_cycles_p);
  localparam logic [cnt_width_lp-1:0] cnt_limit_lp = cnt_width_lp'(timeout_cycles_p - 1);

  logic [cnt_width_lp-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^timeout_cycles_p;
`endif

  logic unused_resp_fields;
  assign unused_resp_fields = ^{resp_msg.header.payload, resp_msg.header.subop, resp_msg.header.size};

  always_comb begin
    state_d         = state_q;
    cmd_d           = cmd_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    req_ready_and_o = 1'b0;
    mem_cmd_v_o     = 1'b0;
    resp_v_o        = 1'b0;
`ifdef BP_MMIO_TIMEOUT_EN
    cnt_d           = cnt_q;
`endif

    unique case (state_q)
      e_ready: begin
        req_ready_and_o = 1'b1;
        if (req_v_i) begin
          cmd_d.header.msg_type       = req_w_i ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
          cmd_d.header.subop          = e_bedrock_store;
          cmd_d.header.addr           = req_addr_i;
          cmd_d.header.size           = req_size_i;
          cmd_d.header.payload.lce_id = lce_id_width_p'(src_id_p);
          cmd_d.header.payload.way_id = '0;
          cmd_d.data                  = req_w_i ? replicate_data(req_data_i, req_size_i) : '0;
          state_d                     = e_send;
        end
      end

      e_send: begin
        mem_cmd_v_o = 1'b1;
        if (mem_cmd_ready_and_i) begin
          state_d = e_wait;
`ifdef BP_MMIO_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      // A response arriving on the timeout cycle takes priority over the watchdog.
      e_wait: begin
        if (mem_resp_v_i) begin
          err_d   = (resp_msg.header.msg_type != cmd_q.header.msg_type)
                  | (resp_msg.header.addr != cmd_q.header.addr);
          rdata_d = cmd_is_wr ? '0 : mask_data(resp_msg.data, cmd_q.header.size);
          state_d = e_done;
        end
`ifdef BP_MMIO_TIMEOUT_EN
        else if (cnt_q == cnt_limit_lp) begin
          err_d   = 1'b1;
          rdata_d = '1;
          state_d = e_done;
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
`endif
      end

      e_done: begin
        resp_v_o = 1'b1;
        if (resp_yumi_i) begin
          state_d = e_ready;
        end
      end

      default: state_d = e_ready;
    endcase

    if (reset_i) begin
      req_ready_and_o = 1'b0;
      mem_cmd_v_o     = 1'b0;
      resp_v_o        = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      cmd_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
